// File: rtl/ah_div_arbiter.sv
// rtl/ah_div_arbiter.sv - round-robin front end sharing one pipelined signed divider
// Tags each issued op with its requester ID and steers the result back after LATENCY cycles.
module ah_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 50,
  parameter int LATENCY = 17,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic                     div_data_valid,
  input  logic                     div_by_zero,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic                     rsp_div_by_zero,
  output logic [CNT_W-1:0]         inflight_cnt,
  output logic                     busy,
  output logic                     tag_err
);

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    div_start_q, div_start_d;
  logic [WIDTH-1:0]        div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]        div_divisor_q, div_divisor_d;
  logic [ID_W-1:0]         issue_id_q, issue_id_d;
  logic [LATENCY-1:0]      tag_v_q, tag_v_d;
  logic [LATENCY*ID_W-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_quotient_q, rsp_quotient_d;
  logic                    rsp_dbz_q, rsp_dbz_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    tag_err_q, tag_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic [ID_W:0]      sum;
  logic [ID_W-1:0]    idx;
  logic               tail_v;
  logic [ID_W-1:0]    tail_id;

  // Search starts at ptr and wraps; only the first valid requester is granted.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!found && !hold && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign tail_v  = tag_v_q[LATENCY-1];
  assign tail_id = tag_id_q[LATENCY*ID_W-1 -: ID_W];

  always_comb begin
    ptr_d          = ptr_q;
    div_start_d    = found;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    issue_id_d     = issue_id_q;
    if (found) begin
      ptr_d          = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      div_dividend_d = req_dividend[grant_id*WIDTH +: WIDTH];
      div_divisor_d  = req_divisor[grant_id*WIDTH +: WIDTH];
      issue_id_d     = grant_id;
    end

    // Tag shifts unconditionally so its tail meets div_data_valid exactly.
    tag_v_d  = {tag_v_q[LATENCY-2:0], div_start_q};
    tag_id_d = {tag_id_q[(LATENCY-1)*ID_W-1:0], issue_id_q};

    rsp_valid_d    = (tail_v && div_data_valid) ? (NUM_REQ'(1) << tail_id) : '0;
    rsp_quotient_d = div_data_valid ? div_quotient : rsp_quotient_q;
    rsp_dbz_d      = div_data_valid ? div_by_zero : rsp_dbz_q;
    tag_err_d      = tag_err_q | (tail_v ^ div_data_valid);

    inflight_d = inflight_q;
    if (div_start_q && !(|rsp_valid_q)) begin
      if (inflight_q < CNT_W'(LATENCY+1)) inflight_d = inflight_q + 1'b1;
    end else if (!div_start_q && (|rsp_valid_q)) begin
      if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      issue_id_q     <= '0;
      tag_v_q        <= '0;
      tag_id_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_quotient_q <= '0;
      rsp_dbz_q      <= 1'b0;
      inflight_q     <= '0;
      tag_err_q      <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      issue_id_q     <= issue_id_d;
      tag_v_q        <= tag_v_d;
      tag_id_q       <= tag_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_dbz_q      <= rsp_dbz_d;
      inflight_q     <= inflight_d;
      tag_err_q      <= tag_err_d;
    end
  end

  assign req_ready       = grant;
  assign div_start       = div_start_q;
  assign div_dividend    = div_dividend_q;
  assign div_divisor     = div_divisor_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_quotient    = rsp_quotient_q;
  assign rsp_div_by_zero = rsp_dbz_q;
  assign inflight_cnt    = inflight_q;
  assign busy            = (inflight_q != '0) || div_start_q;
  assign tag_err         = tag_err_q;

endmodule
